score_ctrl: RTL and testbench
=============================

# score_ctrl

Sequencer that owns the two-digit score display counter. Converts game-level events (new game, point scored, game over) into the counter's clear/increment/enable controls, blinks the display at game over, and can replay an arbitrary value 0–99 into the counter by clearing it and issuing back-to-back increments. Sits between the game FSM and the score display block.

## Interface

Parameters:

- `BLINK_TICKS`, default 16'd6000: cycles per blink half-period (off phase, then on phase). Legal range 1–65535.
- `BLINK_COUNT`, default 3: number of off/on blink periods after game over. Legal range 1–15.

Ports:

- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `new_game` in 1: single-cycle pulse; start a new game at score 0.
- `point` in 1: single-cycle pulse; add 1 to the score.
- `game_over` in 1: single-cycle pulse; end the game and blink.
- `show_high` in 1: level; display the high score while held. Effective only with `SCORE_CTRL_HIGH_SCORE_EN`.
- `score_rst` out 1: clear strobe to the display counter.
- `score_inc` out 1: increment strobe to the display counter.
- `score_ena` out 1: display enable; 0 blanks the display.
- `score` out 7: current game score, binary 0–99.
- `high_score` out 7: best score, binary 0–99. Tied to 0 without the macro.
- `busy` out 1: high in CLEAR and LOAD.

## Operation

- All outputs are registered. Reset values: state=IDLE, `score_rst`=0, `score_inc`=0, `score_ena`=0, `busy`=0, `score`=0, `high_score`=0.
- States:
  - **IDLE**: `score_ena`=0.
  - **CLEAR**: `score_rst`=1 for exactly 1 cycle. Goes to LOAD if the load target is >0, otherwise to the return state.
  - **LOAD**: `score_inc`=1 on each of N consecutive cycles, where N is the load target. Goes to the return state. `score_ena`=0 throughout.
  - **PLAY**: `score_ena`=1.
  - **BLINK**: `score_ena` alternates off then on, each phase lasting `BLINK_TICKS` cycles, for `BLINK_COUNT` periods. Then goes to HOLD.
  - **HOLD**: `score_ena`=1, display static.
- `new_game` is accepted in any state:
  - `score` is set to 0.
  - Goes to CLEAR with load target 0 and return state PLAY.
- `point` is accepted only in PLAY:
  - If `score`<99: `score` increments and `score_inc` pulses 1 cycle.
  - If `score`=99: the point is ignored and no `score_inc` is issued. The score saturates; the display counter's 99→00 wrap is never exercised.
  - In every other state `point` is dropped.
- `game_over` is accepted only in PLAY:
  - Goes to BLINK.
  - In all other states it is ignored.
- Simultaneous events: `new_game` > `game_over` > `point`. Only the highest-priority accepted event acts; the others are dropped.
- `new_game` during CLEAR, LOAD or BLINK aborts the sequence. The load counter and blink timer restart.
- Reset mid-sequence returns to IDLE immediately. Display counter contents are then undefined until the next `new_game`.

## Timing

- `point` sampled high in cycle t → `score_inc` and the new `score` are visible in cycle t+1.
- `new_game` in cycle t → `score_rst`=1 in t+1, `busy`=1 in t+1 → PLAY and `score_ena`=1 in t+2.
- LOAD of value V:
  - `score_rst` in cycle t+1.
  - `score_inc` high in cycles t+2 … t+1+V.
  - Return state entered in t+2+V; `busy` is high from t+1 through t+1+V.
- `game_over` in cycle t → `score_ena`=0 from t+1. Total BLINK duration is 2·`BLINK_TICKS`·`BLINK_COUNT` cycles, then HOLD.

## Configuration

- **`SCORE_CTRL_HIGH_SCORE_EN` defined:**
  - On entering BLINK, if `score`>`high_score`, then `high_score`←`score`.
  - In HOLD, a rising edge of `show_high` starts CLEAR+LOAD(`high_score`) with return state HOLD.
  - A falling edge starts CLEAR+LOAD(`score`) with return state HOLD.
  - An edge that arrives while `busy` is latched. It is served on return, using the `show_high` level at that time.
  - `high_score` survives `new_game`; it is cleared only by `rst`.
- **Not defined:** `show_high` is ignored, `high_score` stays 0, and no high-score register is built.

## Structure

- Package `score_pkg`:
  - State enum (IDLE, CLEAR, LOAD, PLAY, BLINK, HOLD).
  - Constants `SCORE_MAX`=7'd99 and `SCORE_W`=7.
- Sub-module `blink_timer`: a phase counter plus a period counter, with `start`/`ena_out`/`done` signals.
- LOAD uses a 7-bit down-counter in the main block.

## Test plan

- Reset, then `new_game` → `score_rst` 1 cycle, then PLAY with `score_ena`=1, `score`=0, `busy` low after 1 cycle.
- 5 `point` pulses in PLAY → exactly 5 `score_inc` pulses, each one cycle after its `point`; `score`=5.
- 100 `point` pulses → `score`=99 and only 99 `score_inc` pulses; the 100th produces none.
- `BLINK_TICKS`=4, `BLINK_COUNT`=2, `game_over` at `score`=7 → `score_ena` pattern 0000111100001111, then held at 1. A `point` during BLINK produces no `score_inc`.
- Same cycle: `new_game`+`game_over`+`point` in PLAY → only CLEAR occurs, `score`=0. Async `rst` asserted during LOAD → all outputs 0 immediately.
- With macro, game ending at 12 then a game ending at 4, `show_high` raised in HOLD → CLEAR, 12 `score_inc` pulses, `high_score`=12. Dropping `show_high` → CLEAR, 4 `score_inc` pulses.

Source files
------------

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score display sequencer.
//   state_e   : sequencer states (IDLE, CLEAR, LOAD, PLAY, BLINK, HOLD)
//   SCORE_W   : width of the binary score (0..99 fits in 7 bits)
//   SCORE_MAX : saturation value of the game score
// -----------------------------------------------------------------------------
package score_pkg;

   localparam int SCORE_W = 7;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      PLAY,
      BLINK,
      HOLD
   } state_e;

endpackage

// File: rtl/score_ctrl_blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Game-over blink generator: a phase counter (BLINK_TICKS cycles per half
// period) plus a period counter (BLINK_COUNT off/on periods). Each period
// starts with the off phase.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load counters; the following cycle is the first off cycle
//   active    : advance counters (owner is in its blink state)
//   ena_out   : display enable for the NEXT cycle (feeds a registered output)
//   done      : current cycle is the last cycle of the final on phase
// -----------------------------------------------------------------------------
module blink_timer #(
   parameter logic [15:0] BLINK_TICKS = 16'd6000,
   parameter int          BLINK_COUNT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   output logic ena_out,
   output logic done
);

   localparam logic [15:0] LAST_TICK   = BLINK_TICKS - 16'd1;
   localparam logic [3:0]  LAST_PERIOD = 4'(BLINK_COUNT - 1);

   logic [15:0] phase_q, phase_d;
   logic [3:0]  period_q, period_d;
   logic        on_q, on_d;
   logic        phase_end;

   always_comb begin
      phase_end = (phase_q == LAST_TICK);
      phase_d   = phase_q;
      period_d  = period_q;
      on_d      = on_q;
      if (start) begin
         phase_d  = '0;
         period_d = '0;
         on_d     = 1'b0;
      end else if (active) begin
         if (phase_end) begin
            phase_d = '0;
            if (on_q) begin
               on_d     = 1'b0;
               period_d = period_q + 4'd1;
            end else begin
               on_d = 1'b1;
            end
         end else begin
            phase_d = phase_q + 16'd1;
         end
      end
   end

   assign ena_out = on_d;
   assign done    = active && phase_end && on_q && (period_q == LAST_PERIOD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= '0;
         period_q <= '0;
         on_q     <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         period_q <= period_d;
         on_q     <= on_d;
      end
   end

endmodule

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
// Sequencer for the two-digit score display counter. Turns game events into
// clear/increment/enable strobes, blinks the display at game over, and can
// replay any value 0..99 into the counter (clear, then back-to-back incs).
// Optional feature macro: SCORE_CTRL_HIGH_SCORE_EN (high-score register and
// show_high replay while in HOLD).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   new_game    : pulse, restart at score 0 (accepted in any state)
//   point       : pulse, +1 score (PLAY only, saturates at 99)
//   game_over   : pulse, go blink (PLAY only)
//   show_high   : level, show high score while held (HOLD, macro only)
//   score_rst   : clear strobe to display counter
//   score_inc   : increment strobe to display counter
//   score_ena   : display enable
//   score       : game score, binary
//   high_score  : best score, binary (0 without the macro)
//   busy        : high during CLEAR and LOAD
// -----------------------------------------------------------------------------
module score_ctrl
   import score_pkg::*;
#(
   parameter logic [15:0] BLINK_TICKS = 16'd6000,
   parameter int          BLINK_COUNT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic               point,
   input  logic               game_over,
   input  logic               show_high,
   output logic               score_rst,
   output logic               score_inc,
   output logic               score_ena,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               busy
);

   state_e             state_q;
   state_e             ret_q;     // state to enter once CLEAR/LOAD finish
   logic [SCORE_W-1:0] cnt_q;     // remaining increments to issue
   logic [SCORE_W-1:0] score_q;
   logic               rst_q, inc_q, ena_q, busy_q;

   logic tmr_start, tmr_active, tmr_ena, tmr_done;

   assign tmr_start  = (state_q == PLAY) && game_over && !new_game;
   assign tmr_active = (state_q == BLINK);

   blink_timer #(
      .BLINK_TICKS (BLINK_TICKS),
      .BLINK_COUNT (BLINK_COUNT)
   ) u_blink (
      .clk     (clk),
      .rst     (rst),
      .start   (tmr_start),
      .active  (tmr_active),
      .ena_out (tmr_ena),
      .done    (tmr_done)
   );

`ifdef SCORE_CTRL_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q;
   logic               sh_q;     // show_high delayed one cycle, for edges
   logic               pend_q;   // edge seen while replaying, serve on return
   logic               sh_edge;

   assign sh_edge    = show_high ^ sh_q;
   assign high_score = high_q;
`else
   logic unused_show_high;
   assign unused_show_high = show_high;
   assign high_score       = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ret_q   <= PLAY;
         cnt_q   <= '0;
         score_q <= '0;
         rst_q   <= 1'b0;
         inc_q   <= 1'b0;
         ena_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
         high_q  <= '0;
         sh_q    <= 1'b0;
         pend_q  <= 1'b0;
`endif
      end else begin
         // strobes are single-cycle unless a branch re-asserts them
         rst_q <= 1'b0;
         inc_q <= 1'b0;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
         sh_q <= show_high;
         if (busy_q && (ret_q == HOLD) && sh_edge)
            pend_q <= 1'b1;
`endif
         if (new_game) begin
            state_q <= CLEAR;
            ret_q   <= PLAY;
            cnt_q   <= '0;
            score_q <= '0;
            rst_q   <= 1'b1;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
            pend_q  <= 1'b0;
`endif
         end else begin
            case (state_q)
               IDLE: ena_q <= 1'b0;
               CLEAR, LOAD: begin
                  if (cnt_q != '0) begin
                     state_q <= LOAD;
                     cnt_q   <= cnt_q - 7'd1;
                     inc_q   <= 1'b1;
                  end else begin
                     // both return states show the display
                     state_q <= ret_q;
                     busy_q  <= 1'b0;
                     ena_q   <= 1'b1;
                  end
               end
               PLAY: begin
                  if (game_over) begin
                     state_q <= BLINK;
                     ena_q   <= 1'b0;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
                     if (score_q > high_q)
                        high_q <= score_q;
`endif
                  end else if (point && (score_q < SCORE_MAX)) begin
                     score_q <= score_q + 7'd1;
                     inc_q   <= 1'b1;
                  end
               end
               BLINK: begin
                  if (tmr_done) begin
                     state_q <= HOLD;
                     ena_q   <= 1'b1;
                  end else begin
                     ena_q <= tmr_ena;
                  end
               end
               HOLD: begin
                  ena_q <= 1'b1;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
                  // current level picks the value, so a latched edge is
                  // served with whatever show_high is now
                  if (sh_edge || pend_q) begin
                     state_q <= CLEAR;
                     ret_q   <= HOLD;
                     cnt_q   <= show_high ? high_q : score_q;
                     rst_q   <= 1'b1;
                     ena_q   <= 1'b0;
                     busy_q  <= 1'b1;
                     pend_q  <= 1'b0;
                  end
`endif
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign score_rst = rst_q;
   assign score_inc = inc_q;
   assign score_ena = ena_q;
   assign score     = score_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_score_ctrl.sv
module tb_score_ctrl;

   localparam int T = 4;
   localparam int C = 2;

   logic       clk = 1'b0;
   logic       rst, new_game, point, game_over, show_high;
   logic       score_rst, score_inc, score_ena, busy;
   logic [6:0] score, high_score;

   int vectors = 0;
   int miscompares = 0;
   int m_score = 0;   // reference game score
   int m_high  = 0;   // reference high score

   always #5 clk = ~clk;

   score_ctrl #(.BLINK_TICKS(16'(T)), .BLINK_COUNT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .new_game   (new_game),
      .point      (point),
      .game_over  (game_over),
      .show_high  (show_high),
      .score_rst  (score_rst),
      .score_inc  (score_inc),
      .score_ena  (score_ena),
      .score      (score),
      .high_score (high_score),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_rst"},  32'(score_rst), 0);
      chk({tag, "_inc"},  32'(score_inc), 0);
      chk({tag, "_ena"},  32'(score_ena), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_score"}, 32'(score), 0);
      chk({tag, "_high"}, 32'(high_score), 0);
   endtask

   task automatic start_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      chk("ng_rst", 32'(score_rst), 1);
      chk("ng_busy", 32'(busy), 1);
      chk("ng_ena", 32'(score_ena), 0);
      chk("ng_score", 32'(score), 0);
      tick();
      chk("play_rst", 32'(score_rst), 0);
      chk("play_busy", 32'(busy), 0);
      chk("play_ena", 32'(score_ena), 1);
      m_score = 0;
   endtask

   // one point pulse; the model saturates at 99 and only counts real incs
   task automatic do_point(output int incs);
      int exp_inc;
      exp_inc = (m_score < 99) ? 1 : 0;
      if (m_score < 99) m_score++;
      point = 1'b1;
      tick();
      point = 1'b0;
      chk("pt_inc", 32'(score_inc), 32'(exp_inc));
      chk("pt_score", 32'(score), 32'(m_score));
      incs = exp_inc;
   endtask

   task automatic idle_gap();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         tick();
         chk("gap_inc", 32'(score_inc), 0);
      end
   endtask

   task automatic play_to(input int n);
      int d;
      start_game();
      for (int i = 0; i < n; i++) begin
         do_point(d);
         idle_gap();
      end
   endtask

   // game over, blink pattern check with a stray point, then HOLD
   task automatic end_game();
      int pt_at;
      pt_at = $urandom_range(0, 2*T*C - 2);
      if (m_score > m_high) m_high = m_score;
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      for (int i = 0; i < 2*T*C; i++) begin
         chk("blink_ena", 32'(score_ena), 32'((i / T) % 2));
         chk("blink_inc", 32'(score_inc), 0);
         point = (i == pt_at);
         tick();
         point = 1'b0;
      end
      chk("hold_ena", 32'(score_ena), 1);
      chk("hold_score", 32'(score), 32'(m_score));
`ifdef SCORE_CTRL_HIGH_SCORE_EN
      chk("hold_high", 32'(high_score), 32'(m_high));
`else
      chk("hold_high", 32'(high_score), 0);
`endif
      tick();
      chk("hold_ena2", 32'(score_ena), 1);
   endtask

   task automatic window(input int n, output int incs, output int rsts);
      incs = 0;
      rsts = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         incs += int'(score_inc);
         rsts += int'(score_rst);
      end
   endtask

   initial begin
      int incs, rsts, d;
      rst = 1'b1; new_game = 1'b0; point = 1'b0; game_over = 1'b0; show_high = 1'b0;
      tick();
      tick();
      all_zero("reset");
      rst = 1'b0;

      // IDLE ignores point and game_over
      point = 1'b1; game_over = 1'b1;
      tick();
      point = 1'b0; game_over = 1'b0;
      tick();
      all_zero("idle");

      // five points, random spacing
      play_to(5);
      chk("five_score", 32'(score), 5);

      // 100 points: saturate at 99, exactly 99 increments
      start_game();
      incs = 0;
      for (int i = 0; i < 100; i++) begin
         do_point(d);
         incs += d;
         if ($urandom_range(0, 3) == 0) idle_gap();
      end
      chk("sat_incs", 32'(incs), 99);
      chk("sat_score", 32'(score), 99);

      // blink at score 7
      play_to(7);
      end_game();
      window(3, incs, rsts);
      chk("hold_pt_ignored", 32'(score), 7);

      // all three events together in PLAY: only the clear
      play_to(3);
      new_game = 1'b1; game_over = 1'b1; point = 1'b1;
      tick();
      new_game = 1'b0; game_over = 1'b0; point = 1'b0;
      chk("tri_rst", 32'(score_rst), 1);
      chk("tri_inc", 32'(score_inc), 0);
      chk("tri_score", 32'(score), 0);
      tick();
      chk("tri_ena", 32'(score_ena), 1);
      chk("tri_busy", 32'(busy), 0);
      m_score = 0;
      do_point(d);

`ifdef SCORE_CTRL_HIGH_SCORE_EN
      play_to(12);
      end_game();
      play_to(4);
      end_game();
      chk("high_kept", 32'(high_score), 12);

      // rising edge: replay the high score
      show_high = 1'b1;
      window(1 + m_high, incs, rsts);
      chk("sh_up_rsts", 32'(rsts), 1);
      chk("sh_up_incs", 32'(incs), 32'(m_high));
      tick();
      chk("sh_up_busy", 32'(busy), 0);
      chk("sh_up_ena", 32'(score_ena), 1);

      // falling edge: replay the game score
      show_high = 1'b0;
      window(1 + m_score, incs, rsts);
      chk("sh_dn_rsts", 32'(rsts), 1);
      chk("sh_dn_incs", 32'(incs), 32'(m_score));
      tick();
      chk("sh_dn_busy", 32'(busy), 0);

      // edge while busy is latched and served with the level on return
      show_high = 1'b1;
      incs = 0; rsts = 0;
      for (int i = 0; i < 1 + m_high + 1 + 1 + m_score; i++) begin
         tick();
         incs += int'(score_inc);
         rsts += int'(score_rst);
         if (i == 2) show_high = 1'b0;
      end
      chk("latch_rsts", 32'(rsts), 2);
      chk("latch_incs", 32'(incs), 32'(m_high + m_score));
      tick();
      chk("latch_busy", 32'(busy), 0);
      chk("latch_inc", 32'(score_inc), 0);

      // async reset in the middle of LOAD
      show_high = 1'b1;
      tick();
      tick();
      chk("load_inc", 32'(score_inc), 1);
      #2 rst = 1'b1;
      #1 all_zero("rst_load");
      #1 rst = 1'b0;
      show_high = 1'b0;
      m_high = 0;
`else
      play_to(12);
      end_game();
      // show_high has no effect without the feature
      show_high = 1'b1;
      window(4, incs, rsts);
      show_high = 1'b0;
      window(4, d, rsts);
      chk("nosh_incs", 32'(incs + d), 0);
      chk("nosh_rsts", 32'(rsts), 0);
      chk("nosh_busy", 32'(busy), 0);

      // async reset in the middle of CLEAR
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      #2 rst = 1'b1;
      #1 all_zero("rst_clear");
      #1 rst = 1'b0;
`endif
      tick();
      point = 1'b1;
      tick();
      point = 1'b0;
      all_zero("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
